rv_axi_rd_arb: RTL and testbench

- Parametrised AXI read-channel arbiter; merges NCH cache read masters (d-cache, i-cache, further caches/DMA) onto one memc AXI read port.
- Replaces fixed-priority two-way AR muxing with round-robin AR arbitration, a bounded outstanding-burst queue and R-beat routing back to the owning channel.
- Sits between the rv_cache instances and the memc/axi_ic read port, in the aclk domain.

---
 rtl/rv_axi_rd_arb.sv | 204 ++++++++++++++++++++
 tb/tb_rv_axi_rd_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_axi_rd_arb.sv
`default_nettype none
// ============================================================================
// rv_axi_rd_arb : round-robin AXI read arbiter, NCH cache masters -> one memc
//                 read port, with outstanding-burst tracking and R routing.
// Option macro  : RV_ARB_RID_EN (ID-tagged AR, out-of-order R by m_rid)
// Revision      : 1.0
// ============================================================================
module rv_axi_rd_arb #(
    parameter int NCH = 2,
    parameter int AW  = 28,
    parameter int DW  = 32,
    parameter int OSD = 4
) (
    input  logic                      aclk,
    input  logic                      arst_n,
    input  logic [NCH*AW-1:0]         s_araddr,
    input  logic [NCH*8-1:0]          s_arlen,
    input  logic [NCH-1:0]            s_arvalid,
    output logic [NCH-1:0]            s_arready,
    output logic [DW-1:0]             s_rdata,
    output logic [NCH-1:0]            s_rvalid,
    output logic [NCH-1:0]            s_rlast,
    input  logic [NCH-1:0]            s_rready,
`ifdef RV_ARB_RID_EN
    output logic [$clog2(NCH)-1:0]    m_arid,
`else
    output logic                      m_arid,
`endif
    output logic [AW-1:0]             m_araddr,
    output logic [7:0]                m_arlen,
    output logic                      m_arvalid,
    input  logic                      m_arready,
`ifdef RV_ARB_RID_EN
    input  logic [$clog2(NCH)-1:0]    m_rid,
`else
    input  logic                      m_rid,
`endif
    input  logic [DW-1:0]             m_rdata,
    input  logic                      m_rlast,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    output logic [$clog2(OSD):0]      outstanding,
    output logic                      err
);
    localparam int GW = $clog2(NCH);
    localparam int PW = $clog2(OSD);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(OSD);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ADDR = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] gnt;
    logic [GW-1:0] last;
    logic [GW-1:0] pick;
    logic [GW-1:0] cand;
    logic          found;
    logic          full;
    logic          push;
    logic [PW:0]   count;

    // Round-robin: first requester strictly after the last winner, with wrap.
    always_comb begin
        pick  = last;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            cand = GW'((int'(last) + i) % NCH);
            if (!found && s_arvalid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign full = (count == FULL_CNT);

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_IDLE;
            gnt   <= '0;
            last  <= GW'(NCH-1);
        end else begin
            case (state)
                S_IDLE: if (found && !full) begin
                    gnt   <= pick;
                    state <= S_ADDR;
                end
                S_ADDR: if (m_arready) begin
                    last  <= gnt;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign m_arvalid = (state == S_ADDR);
    assign push      = m_arvalid && m_arready;
    assign s_rdata   = m_rdata;
    assign outstanding = count;

    always_comb begin
        m_araddr  = '0;
        m_arlen   = '0;
        s_arready = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt == GW'(k)) begin
                m_araddr = s_araddr[k*AW +: AW];
                m_arlen  = s_arlen[k*8 +: 8];
            end
        end
        if (m_arvalid) s_arready[gnt] = m_arready;
    end

`ifdef RV_ARB_RID_EN
    logic [PW:0] cnt [NCH];
    logic        rid_ok;
    logic        last_beat;
    logic        dec;

    assign m_arid    = gnt;
    assign rid_ok    = ({1'b0, m_rid} < (GW+1)'(NCH));
    assign last_beat = m_rvalid && m_rready && m_rlast;
    assign dec       = last_beat && rid_ok && (cnt[m_rid] != '0);

    // Unknown IDs are drained so memc can never deadlock on a stray beat.
    always_comb begin
        s_rvalid = '0;
        s_rlast  = '0;
        m_rready = 1'b1;
        if (rid_ok) begin
            s_rvalid[m_rid] = m_rvalid;
            s_rlast[m_rid]  = m_rlast;
            m_rready        = s_rready[m_rid];
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < NCH; k++) cnt[k] <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (push && gnt == GW'(k) && !(dec && m_rid == GW'(k)))
                    cnt[k] <= cnt[k] + (PW+1)'(1);
                else if (dec && m_rid == GW'(k) && !(push && gnt == GW'(k)))
                    cnt[k] <= cnt[k] - (PW+1)'(1);
            end
            if (push && !dec)      count <= count + (PW+1)'(1);
            else if (dec && !push) count <= count - (PW+1)'(1);
            if (last_beat && !dec) err <= 1'b1;
        end
    end
`else
    logic [GW-1:0] fifo [OSD];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [GW-1:0] head;
    logic          empty;
    logic          pop;
    logic          unused_rid;

    assign m_arid     = 1'b0;
    assign unused_rid = m_rid;
    assign head       = fifo[rd_ptr];
    assign empty      = (count == '0);
    assign pop        = !empty && m_rvalid && m_rready && m_rlast;

    // With nothing queued the beat has no owner; accept it and flag the error.
    always_comb begin
        s_rvalid = '0;
        s_rlast  = '0;
        m_rready = 1'b1;
        if (!empty) begin
            s_rvalid[head] = m_rvalid;
            s_rlast[head]  = m_rlast;
            m_rready       = s_rready[head];
        end
    end

    always_ff @(posedge aclk) begin
        if (push) fifo[wr_ptr] <= gnt;
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (pop && !push) count <= count - (PW+1)'(1);
            if (m_rvalid && empty) err <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_axi_rd_arb.sv
`default_nettype none
// ============================================================================
// tb_rv_axi_rd_arb : directed scoreboard bench for rv_axi_rd_arb (default build)
// Revision         : 1.0
// ============================================================================
module tb_rv_axi_rd_arb;
    localparam int NCH = 2;
    localparam int AW  = 28;
    localparam int DW  = 32;
    localparam int OSD = 4;

    logic              aclk = 1'b0;
    logic              arst_n;
    logic [NCH*AW-1:0] s_araddr;
    logic [NCH*8-1:0]  s_arlen;
    logic [NCH-1:0]    s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic [DW-1:0]     s_rdata;
    logic              m_arid;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic              m_arvalid, m_arready, m_rid;
    logic [DW-1:0]     m_rdata;
    logic              m_rlast, m_rvalid, m_rready;
    logic [2:0]        outstanding;
    logic              err;

    always #5 aclk = ~aclk;

    rv_axi_rd_arb #(.NCH(NCH), .AW(AW), .DW(DW), .OSD(OSD)) dut (
        .aclk(aclk), .arst_n(arst_n),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .outstanding(outstanding), .err(err)
    );

    typedef struct { int ch; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct { int ch; logic [DW-1:0] data; logic last; } r_t;

    ar_t ar_exp[$];
    ar_t owners[$];
    r_t  r_exp[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [AW-1:0] a, input logic [7:0] l, input bit push_exp);
        s_araddr[ch*AW +: AW] = a;
        s_arlen[ch*8 +: 8]    = l;
        s_arvalid[ch]         = 1'b1;
        if (push_exp) ar_exp.push_back('{ch: ch, addr: a, len: l});
    endtask

    task automatic wait_arvalid();
        int n = 0;
        while (!m_arvalid && n < 8) begin
            tick();
            n++;
        end
        check("arvalid_wait", m_arvalid, 1);
    endtask

    task automatic accept_ar(input bit keep);
        ar_t e;
        if (ar_exp.size() == 0) begin
            check("ar_exp_empty", ar_exp.size(), 1);
            return;
        end
        e = ar_exp.pop_front();
        check("ar_valid", m_arvalid, 1);
        check("ar_addr", m_araddr, e.addr);
        check("ar_len", m_arlen, e.len);
        m_arready = 1'b1;
        #1;
        check("ar_ready", s_arready, 64'(1) << e.ch);
        tick();
        m_arready = 1'b0;
        if (!keep) s_arvalid[e.ch] = 1'b0;
        owners.push_back(e);
    endtask

    task automatic drain_burst(input int stall_at, input int stall_n);
        ar_t o;
        r_t  e;
        logic [NCH-1:0] onehot;
        if (owners.size() == 0) begin
            check("owner_empty", owners.size(), 1);
            return;
        end
        o = owners.pop_front();
        for (int b = 0; b <= int'(o.len); b++) begin
            r_exp.push_back('{ch: o.ch, data: DW'(o.addr) + DW'(b), last: (b == int'(o.len))});
            m_rvalid = 1'b1;
            m_rdata  = DW'(o.addr) + DW'(b);
            m_rlast  = (b == int'(o.len));
            if (b == stall_at) begin
                s_rready[o.ch] = 1'b0;
                repeat (stall_n) begin
                    #1;
                    check("stall_m_rready", m_rready, 0);
                    check("stall_s_rvalid", s_rvalid, 64'(1) << o.ch);
                    check("stall_outstanding", outstanding, owners.size() + 1);
                    tick();
                end
                s_rready[o.ch] = 1'b1;
            end
            #1;
            e = r_exp.pop_front();
            onehot = NCH'(1) << e.ch;
            check("r_valid", s_rvalid, onehot);
            check("r_last", s_rlast, e.last ? onehot : '0);
            check("r_data", s_rdata, e.data);
            check("r_m_rready", m_rready, 1);
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        #1;
        check("rst_arvalid", m_arvalid, 0);
        check("rst_arready", s_arready, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err, 0);
        tick();
        arst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n    = 1'b1;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arvalid = '0;
        s_rready  = '1;
        m_arready = 1'b0;
        m_rid     = 1'b0;
        m_rdata   = '0;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b0;
        #2;
        do_reset();

        // Single request: one-cycle AR latency, 8 beats to ch0 only
        set_req(0, 28'h0000100, 8'd7, 1'b1);
        tick();
        check("single_latency", m_arvalid, 1);
        accept_ar(1'b0);
        check("single_osd_1", outstanding, 1);
        drain_burst(-1, 0);
        check("single_osd_0", outstanding, 0);

        // Contention from reset: order 0,1,0,1 with a held address, then queue full
        do_reset();
        s_araddr[0 +: AW]  = 28'h0000A00;
        s_araddr[AW +: AW] = 28'h0000B00;
        s_arlen[0 +: 8]    = 8'd0;
        s_arlen[8 +: 8]    = 8'd1;
        s_arvalid          = 2'b11;
        for (int g = 0; g < 4; g++)
            ar_exp.push_back('{ch: g % 2, addr: (g % 2 == 0) ? 28'h0000A00 : 28'h0000B00,
                               len: (g % 2 == 0) ? 8'd0 : 8'd1});
        for (int g = 0; g < 4; g++) begin
            wait_arvalid();
            if (g == 0) begin
                repeat (3) begin
                    check("hold_addr", m_araddr, 28'h0000A00);
                    check("hold_arready", s_arready, 0);
                    tick();
                end
            end
            accept_ar(1'b1);
        end
        check("full_osd", outstanding, 4);
        repeat (3) begin
            tick();
            check("full_no_grant", m_arvalid, 0);
        end
        drain_burst(-1, 0);
        check("pop_cycle_no_grant", m_arvalid, 0);
        check("pop_osd", outstanding, 3);
        tick();
        check("regrant_valid", m_arvalid, 1);
        ar_exp.push_back('{ch: 0, addr: 28'h0000A00, len: 8'd0});
        accept_ar(1'b0);
        s_arvalid = '0;
        repeat (4) drain_burst(-1, 0);
        check("contention_osd_0", outstanding, 0);

        // In-order routing: ch1 (4 beats, stalled) then ch0 (1 beat)
        set_req(1, 28'h0000300, 8'd3, 1'b1);
        tick();
        accept_ar(1'b0);
        set_req(0, 28'h0000400, 8'd0, 1'b1);
        tick();
        accept_ar(1'b0);
        check("inorder_osd", outstanding, 2);
        drain_burst(1, 2);
        drain_burst(-1, 0);
        check("inorder_osd_0", outstanding, 0);

        // Stray beat with an empty queue: drained, no routing, sticky err
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        #1;
        check("stray_m_rready", m_rready, 1);
        check("stray_s_rvalid", s_rvalid, 0);
        tick();
        check("stray_err", err, 1);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        tick();
        check("err_sticky", err, 1);

        // Asynchronous reset in the middle of a burst with a pending grant
        set_req(0, 28'h0000500, 8'd3, 1'b1);
        tick();
        accept_ar(1'b0);
        m_rvalid = 1'b1;
        m_rdata  = 32'h0000_0500;
        m_rlast  = 1'b0;
        #1;
        check("mid_rvalid", s_rvalid, 2'b01);
        tick();
        set_req(1, 28'h0000600, 8'd0, 1'b0);
        tick();
        check("mid_arvalid", m_arvalid, 1);
        #3;
        arst_n = 1'b0;
        #1;
        check("async_arvalid", m_arvalid, 0);
        check("async_arready", s_arready, 0);
        check("async_outstanding", outstanding, 0);
        check("async_err", err, 0);
        check("async_s_rvalid", s_rvalid, 0);
        owners.delete();
        ar_exp.delete();
        m_rvalid  = 1'b0;
        s_arvalid = '0;
        tick();
        arst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
